// File: rtl/input_frame_serializer.sv
// input_frame_serializer
// Front end of the first conv layer. Takes one multi-channel pixel per beat,
// tracks its column/row inside the frame and emits it as CHANNEL_NUM
// consecutive DATA_WIDTH words with row (sop/eop) and frame (sof/eof) markers.
//
// Handshake: a pixel is accepted on a rising clk edge where
// pix_valid_i & ready_o are both 1; pix_i and pix_sof_i are sampled only on
// that edge, and the source must hold pix_i while ready_o is 0. The output
// side has no back-pressure: every cycle with data_valid_o = 1 carries one
// word.
module input_frame_serializer #(
  parameter int DATA_WIDTH  = 8,
  parameter int CHANNEL_NUM = 3,
  parameter int IMG_WIDTH   = 224,
  parameter int IMG_HEIGHT  = 224
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [CHANNEL_NUM*DATA_WIDTH-1:0] pix_i,
  input  logic                              pix_valid_i,
  input  logic                              pix_sof_i,
  output logic                              ready_o,
  output logic [DATA_WIDTH-1:0]             data_o,
  output logic                              data_valid_o,
  output logic                              sop_o,
  output logic                              eop_o,
  output logic                              sof_o,
  output logic                              eof_o,
  output logic                              frame_err_o,
  output logic                              dbg_state_o
);

  localparam int PW = CHANNEL_NUM * DATA_WIDTH;
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int KW = $clog2(CHANNEL_NUM);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [KW-1:0] CH_LAST  = KW'(CHANNEL_NUM - 1);
  localparam logic [KW-1:0] CH_PEN   = KW'(CHANNEL_NUM - 2);

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } state_t;

  // Frame tracking: r_col/r_row hold the position the next pixel will take.
  state_t          r_state;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic            r_err;

  // Serializer: r_shift holds the channels not yet driven, lowest first.
  logic [PW-1:0]         r_shift;
  logic [KW-1:0]         r_ch;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_pix_eop;
  logic                  r_pix_eof;
  logic                  r_sop;
  logic                  r_eop;
  logic                  r_sof;
  logic                  r_eof;

  logic            w_accept;
  logic            w_take;
  logic            w_last_ch;
  logic [CW-1:0]   w_pos_col;
  logic [RW-1:0]   w_pos_row;
  logic            w_col_last;
  logic            w_row_last;
  logic            w_frame_last;
  logic            w_mid_sof;

  // Position and control decode for the pixel being offered this cycle.
  always_comb begin
    w_last_ch    = (r_ch == CH_LAST);
    ready_o      = ~r_valid | w_last_ch;
    w_accept     = pix_valid_i & ready_o;
    // In WAIT_SOF only a sof-qualified pixel is kept; everything else is dropped.
    w_take       = w_accept & ((r_state == ACTIVE) | pix_sof_i);
    // A sof pixel always restarts the frame at (0,0), whatever the counters say.
    w_pos_col    = pix_sof_i ? '0 : r_col;
    w_pos_row    = pix_sof_i ? '0 : r_row;
    w_col_last   = (w_pos_col == COL_LAST);
    w_row_last   = (w_pos_row == ROW_LAST);
    w_frame_last = w_col_last & w_row_last;
    w_mid_sof    = w_accept & pix_sof_i & (r_state == ACTIVE) &
                   ((r_col != '0) | (r_row != '0));
  end

  // Frame FSM with column/row counters and the mid-frame sof error pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= WAIT_SOF;
      r_col   <= '0;
      r_row   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_mid_sof;
      if (w_take) begin
        if (w_frame_last) begin
          // Last pixel of the frame: its words still drain from the serializer.
          r_state <= WAIT_SOF;
          r_col   <= '0;
          r_row   <= '0;
        end else begin
          r_state <= ACTIVE;
          if (w_col_last) begin
            r_col <= '0;
            r_row <= w_pos_row + 1'b1;
          end else begin
            r_col <= w_pos_col + 1'b1;
            r_row <= w_pos_row;
          end
        end
      end
    end
  end

  // Channel serializer and marker registers, aligned with each output word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift   <= '0;
      r_ch      <= '0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_pix_eop <= 1'b0;
      r_pix_eof <= 1'b0;
      r_sop     <= 1'b0;
      r_eop     <= 1'b0;
      r_sof     <= 1'b0;
      r_eof     <= 1'b0;
    end else if (w_take) begin
      // Load: channel 0 goes out next cycle, the rest wait in r_shift.
      r_data    <= pix_i[DATA_WIDTH-1:0];
      r_shift   <= pix_i >> DATA_WIDTH;
      r_ch      <= '0;
      r_valid   <= 1'b1;
      r_pix_eop <= w_col_last;
      r_pix_eof <= w_frame_last;
      r_sop     <= (w_pos_col == '0);
      r_sof     <= (w_pos_col == '0) & (w_pos_row == '0);
      r_eop     <= 1'b0;
      r_eof     <= 1'b0;
    end else if (r_valid && !w_last_ch) begin
      // Step to the next channel; row/frame end flags ride on the last one.
      r_data  <= r_shift[DATA_WIDTH-1:0];
      r_shift <= r_shift >> DATA_WIDTH;
      r_ch    <= r_ch + 1'b1;
      r_sop   <= 1'b0;
      r_sof   <= 1'b0;
      r_eop   <= (r_ch == CH_PEN) & r_pix_eop;
      r_eof   <= (r_ch == CH_PEN) & r_pix_eof;
    end else if (r_valid) begin
      // Last channel done and nothing new loaded: go idle, data_o holds.
      r_valid <= 1'b0;
      r_ch    <= '0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
    end
  end

  assign data_o       = r_data;
  assign data_valid_o = r_valid;
  assign sop_o        = r_sop;
  assign eop_o        = r_eop;
  assign sof_o        = r_sof;
  assign eof_o        = r_eof;
  assign frame_err_o  = r_err;
  assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_input_frame_serializer.sv
// tb_input_frame_serializer
// Directed bench for input_frame_serializer with a 4x2 frame of 3-channel
// pixels. Expected words are queued as {sof,eof,sop,eop,data} when a pixel is
// accepted; a negedge monitor pops and compares every output cycle.
module tb_input_frame_serializer;

  localparam int DW = 8;
  localparam int CN = 3;
  localparam int IW = 4;
  localparam int IH = 2;
  localparam int EW = DW + 4;

  logic              clk;
  logic              reset_n;
  logic [CN*DW-1:0]  pix_i;
  logic              pix_valid_i;
  logic              pix_sof_i;
  logic              ready_o;
  logic [DW-1:0]     data_o;
  logic              data_valid_o;
  logic              sop_o;
  logic              eop_o;
  logic              sof_o;
  logic              eof_o;
  logic              frame_err_o;
  logic              dbg_state_o;

  int total = 0;
  int bad   = 0;
  int pos_cnt = 0;
  int err_edge = -1;
  logic [DW-1:0] last_d = '0;
  logic [EW-1:0] exp_q[$];

  input_frame_serializer #(
    .DATA_WIDTH (DW),
    .CHANNEL_NUM(CN),
    .IMG_WIDTH  (IW),
    .IMG_HEIGHT (IH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pix_i       (pix_i),
    .pix_valid_i (pix_valid_i),
    .pix_sof_i   (pix_sof_i),
    .ready_o     (ready_o),
    .data_o      (data_o),
    .data_valid_o(data_valid_o),
    .sop_o       (sop_o),
    .eop_o       (eop_o),
    .sof_o       (sof_o),
    .eof_o       (eof_o),
    .frame_err_o (frame_err_o),
    .dbg_state_o (dbg_state_o)
  );

  // Clock and edge counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) pos_cnt <= pos_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one pixel and wait for acceptance; queue its words when it is kept.
  task automatic send_pix(input logic [CN*DW-1:0] p, input logic s, input bit emit,
                          input int col, input int row, input bit err);
    int guard;
    bit sp, ep, sf, ef;
    guard = 0;
    @(negedge clk);
    pix_i = p;
    pix_sof_i = s;
    pix_valid_i = 1'b1;
    while (!ready_o && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) chk("ready_timeout", 32'(ready_o), 32'd1);
    if (err) err_edge = pos_cnt + 1;
    if (emit) begin
      sp = (col == 0);
      ep = (col == IW - 1);
      sf = sp && (row == 0);
      ef = ep && (row == IH - 1);
      exp_q.push_back({sf, 1'b0, sp, 1'b0, p[DW-1:0]});
      exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b0, p[2*DW-1:DW]});
      exp_q.push_back({1'b0, ef, 1'b0, ep, p[3*DW-1:2*DW]});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pix_valid_i = 1'b0;
      pix_sof_i = 1'b0;
    end
  endtask

  // Asynchronous reset in mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    pix_valid_i = 1'b0;
    pix_sof_i = 1'b0;
    #1;
    chk({tag, "_rst_valid"}, 32'(data_valid_o), 32'd0);
    chk({tag, "_rst_data"}, 32'(data_o), 32'd0);
    chk({tag, "_rst_marks"}, 32'({sop_o, eop_o, sof_o, eof_o, frame_err_o}), 32'd0);
    chk({tag, "_rst_ready"}, 32'(ready_o), 32'd1);
    chk({tag, "_rst_state"}, 32'(dbg_state_o), 32'd0);
    exp_q.delete();
    last_d = '0;
    err_edge = -1;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic logic [CN*DW-1:0] mkpix(input int base, input int n);
    logic [7:0] b;
    b = 8'(base + 3 * n);
    return {b + 8'd2, b + 8'd1, b};
  endfunction

  task automatic send_frame(input int base);
    for (int i = 0; i < IW * IH; i++)
      send_pix(mkpix(base, i), (i == 0), 1'b1, i % IW, i / IW, 1'b0);
  endtask

  // Scoreboard monitor: every cycle outside reset is compared.
  always @(negedge clk) begin
    if (reset_n) begin
      if (data_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'(data_valid_o), 32'd0);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          chk("word", 32'({sof_o, eof_o, sop_o, eop_o, data_o}), 32'(e));
          last_d = e[DW-1:0];
        end
      end else begin
        chk("idle_marks", 32'({sof_o, eof_o, sop_o, eop_o}), 32'd0);
        chk("idle_hold", 32'(data_o), 32'(last_d));
      end
      chk("frame_err", 32'(frame_err_o), 32'(err_edge == pos_cnt));
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    reset_n = 1'b0;
    pix_i = '0;
    pix_valid_i = 1'b0;
    pix_sof_i = 1'b0;
    #1;
    chk("reset_valid", 32'(data_valid_o), 32'd0);
    chk("reset_ready", 32'(ready_o), 32'd1);
    chk("reset_data", 32'(data_o), 32'd0);
    chk("reset_state", 32'(dbg_state_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: full frame back-to-back
    send_frame(8'h10);
    chk("t1_state_active", 32'(dbg_state_o), 32'd1);
    idle(6);
    chk("t1_drained", 32'(exp_q.size()), 32'd0);
    chk("t1_state_wait", 32'(dbg_state_o), 32'd0);

    // 2: latency and ready pattern for a single pixel
    send_pix(24'h030201, 1'b1, 1'b1, 0, 0, 1'b0);
    @(negedge clk);
    pix_valid_i = 1'b0;
    pix_sof_i = 1'b0;
    chk("t2_data_t1", 32'(data_o), 32'h01);
    chk("t2_ready_t1", 32'(ready_o), 32'd0);
    @(negedge clk);
    chk("t2_data_t2", 32'(data_o), 32'h02);
    chk("t2_ready_t2", 32'(ready_o), 32'd0);
    @(negedge clk);
    chk("t2_data_t3", 32'(data_o), 32'h03);
    chk("t2_ready_t3", 32'(ready_o), 32'd1);
    idle(2);
    do_reset("t2");

    // 3: pixels without sof are dropped, then a normal frame
    for (int i = 0; i < 3; i++)
      send_pix(mkpix(8'hA0, i), 1'b0, 1'b0, 0, 0, 1'b0);
    idle(3);
    chk("t3_state_wait", 32'(dbg_state_o), 32'd0);
    send_frame(8'h40);
    idle(6);
    chk("t3_drained", 32'(exp_q.size()), 32'd0);

    // 4: sof on pixel 5 aborts the frame and starts a new one
    for (int i = 0; i < 5; i++)
      send_pix(mkpix(8'h60, i), (i == 0), 1'b1, i % IW, i / IW, 1'b0);
    send_pix(mkpix(8'h80, 0), 1'b1, 1'b1, 0, 0, 1'b1);
    for (int i = 1; i < IW * IH; i++)
      send_pix(mkpix(8'h80, i), 1'b0, 1'b1, i % IW, i / IW, 1'b0);
    idle(6);
    chk("t4_drained", 32'(exp_q.size()), 32'd0);
    chk("t4_state_wait", 32'(dbg_state_o), 32'd0);

    // 5: random gaps between pixels
    for (int i = 0; i < IW * IH; i++) begin
      send_pix(mkpix(8'hC0, i), (i == 0), 1'b1, i % IW, i / IW, 1'b0);
      idle($urandom_range(0, 4));
    end
    idle(6);
    chk("t5_drained", 32'(exp_q.size()), 32'd0);

    // 6: reset in mid-frame, then a clean frame
    for (int i = 0; i < 3; i++)
      send_pix(mkpix(8'h20, i), (i == 0), 1'b1, i % IW, i / IW, 1'b0);
    do_reset("t6");
    send_pix(mkpix(8'hE0, 0), 1'b0, 1'b0, 0, 0, 1'b0);
    idle(2);
    chk("t6_state_wait", 32'(dbg_state_o), 32'd0);
    send_frame(8'h30);
    idle(6);
    chk("t6_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
